// File: rtl/inst_mem_loader_if.sv
// Byte-stream, control and instruction-memory write signals of the boot loader.
// The master modport is the host/test side and the slave modport is the loader.
interface inst_mem_loader_if;
    logic        Start;
    logic        In_Valid;
    logic [7:0]  In_Data;
    logic        In_Ready;
    logic        Inst_Wr_En;
    logic [63:0] Inst_Wr_Address;
    logic [31:0] Inst_Wr_Data;
    logic        Load_Done;
    logic        Load_Error;
    logic        Cpu_Hold;

    modport master (
        output Start,
        output In_Valid,
        output In_Data,
        input  In_Ready,
        input  Inst_Wr_En,
        input  Inst_Wr_Address,
        input  Inst_Wr_Data,
        input  Load_Done,
        input  Load_Error,
        input  Cpu_Hold
    );

    modport slave (
        input  Start,
        input  In_Valid,
        input  In_Data,
        output In_Ready,
        output Inst_Wr_En,
        output Inst_Wr_Address,
        output Inst_Wr_Data,
        output Load_Done,
        output Load_Error,
        output Cpu_Hold
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader: parses a length/payload/XOR-checksum byte frame,
// writes little-endian 32-bit words and holds the core until a load succeeds.
module inst_mem_loader #(
    parameter int unsigned MEM_BYTES = 96
) (
    input logic               clk,
    input logic               reset,
    inst_mem_loader_if.slave  bus
);

    localparam int unsigned MaxWords = MEM_BYTES / 4;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic        accept;
    logic        start_load;
    logic        last_byte;
    logic [15:0] len_next;

    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [7:0]  csum_q;
    logic [23:0] word_q;      // lanes 0..2; lane 3 goes straight from In_Data to the write
    logic        wr_en_q;
    logic [63:0] wr_addr_q;
    logic [31:0] wr_data_q;

    assign accept     = bus.In_Valid && bus.In_Ready;
    assign start_load = bus.Start && (state_q inside {StIdle, StDone, StErr});
    assign last_byte  = (byte_idx_q == 2'd3) && ((word_idx_q + 16'd1) == len_q);
    assign len_next   = {bus.In_Data, len_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_load) state_d = StLenLo;
            end
            StLenLo: begin
                if (accept) state_d = StLenHi;
            end
            StLenHi: begin
                if (accept) begin
                    if (32'(len_next) > MaxWords) state_d = StErr;
                    else if (len_next == 16'd0)   state_d = StCsum;
                    else                          state_d = StData;
                end
            end
            StData: begin
                if (accept && last_byte) state_d = StCsum;
            end
            StCsum: begin
                if (accept) state_d = (bus.In_Data == csum_q) ? StDone : StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.In_Ready        = state_q inside {StLenLo, StLenHi, StData, StCsum};
        bus.Load_Done       = (state_q == StDone);
        bus.Load_Error      = (state_q == StErr);
        bus.Cpu_Hold        = (state_q != StDone);
        bus.Inst_Wr_En      = wr_en_q;
        bus.Inst_Wr_Address = wr_addr_q;
        bus.Inst_Wr_Data    = wr_data_q;
    end

    // Datapath: length capture, word assembly, checksum and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_load) begin
                word_idx_q <= '0;
                byte_idx_q <= '0;
                csum_q     <= '0;
            end
            if (accept) begin
                case (state_q)
                    StLenLo: len_q[7:0]  <= bus.In_Data;
                    StLenHi: len_q[15:8] <= bus.In_Data;
                    StData: begin
                        csum_q     <= csum_q ^ bus.In_Data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_q[7:0]   <= bus.In_Data;
                            2'd1: word_q[15:8]  <= bus.In_Data;
                            2'd2: word_q[23:16] <= bus.In_Data;
                            default: begin
                                wr_en_q    <= 1'b1;
                                wr_addr_q  <= {46'd0, word_idx_q, 2'b00};
                                wr_data_q  <= {bus.In_Data, word_q};
                                word_idx_q <= word_idx_q + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes are queued as bytes are driven
// and matched (address, data, cycle) against every observed write strobe.
module tb_inst_mem_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   start_noise = 1'b0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame_q[$];

    inst_mem_loader_if bus ();

    inst_mem_loader #(.MEM_BYTES(96)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every write strobe must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (bus.Inst_Wr_En === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", bus.Inst_Wr_En, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", bus.Inst_Wr_Address, e.addr);
                check("wr_data", bus.Inst_Wr_Data, 64'(e.data));
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Entered and left at posedge+1; t is the cycle in which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, output int t);
        bit done;
        done = 1'b0;
        bus.In_Valid = 1'b1;
        bus.In_Data  = b;
        bus.Start    = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.In_Ready === 1'b1) begin
                t    = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            check("ready_timeout", bus.In_Ready, 1);
            t = -10;
        end
        bus.In_Valid = 1'b0;
        bus.Start    = 1'b0;
    endtask

    task automatic start_load();
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        @(negedge clk);
        check("start_ready", bus.In_Ready, 1);
        check("start_done_clr", bus.Load_Done, 0);
        check("start_err_clr", bus.Load_Error, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int stall_max, input bit check_end);
        int          n;
        int          t;
        int          p;
        int          k;
        logic [7:0]  x;
        logic [31:0] w;
        bit          ok;
        n = 0;
        x = '0;
        w = '0;
        if (frame_q.size() >= 2) n = int'({frame_q[1], frame_q[0]});
        for (int i = 0; i < frame_q.size(); i++) begin
            k = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
            if (k > 0) begin
                repeat (k) @(posedge clk);
                #1;
            end
            send_byte(frame_q[i], t);
            if (i >= 2 && i < 2 + 4 * n) begin
                p = i - 2;
                w[8 * (p % 4) +: 8] = frame_q[i];
                x = x ^ frame_q[i];
                if (p % 4 == 3) exp_q.push_back('{64'(4 * (p / 4)), w, t + 1});
            end
            if (i == 1 && n > 24) break;
        end
        if (check_end) begin
            ok = (n <= 24) && (frame_q.size() == 3 + 4 * n) && (frame_q[frame_q.size() - 1] == x);
            @(negedge clk);
            check("end_ready", bus.In_Ready, 0);
            check("end_done", bus.Load_Done, 64'(ok));
            check("end_error", bus.Load_Error, 64'(!ok));
            check("end_hold", bus.Cpu_Hold, 64'(!ok));
            repeat (3) @(posedge clk);
            #1;
            check("sb_empty", 64'(exp_q.size()), 0);
        end
    endtask

    task automatic good_frame(input logic [7:0] last);
        frame_q = '{8'h03, 8'h00, 8'h13, 8'h03, 8'h10, 8'h00, 8'h93, 8'h03,
                    8'h40, 8'h00, 8'h13, 8'h04, 8'h50, 8'h00, last};
    endtask

    initial begin
        bus.Start    = 1'b0;
        bus.In_Valid = 1'b1;
        bus.In_Data  = 8'h5a;
        // Reset held two cycles with bytes offered.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.In_Data = 8'($urandom);
            check("rst_ready", bus.In_Ready, 0);
            check("rst_hold", bus.Cpu_Hold, 1);
            check("rst_done", bus.Load_Done, 0);
            check("rst_error", bus.Load_Error, 0);
            check("rst_wr_en", bus.Inst_Wr_En, 0);
            check("rst_addr", bus.Inst_Wr_Address, 0);
            check("rst_data", bus.Inst_Wr_Data, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.In_Valid = 1'b0;
        @(posedge clk);
        #1;

        // Good load, one byte per cycle.
        start_load();
        good_frame(8'h97);
        run_frame(0, 1'b1);

        // Checksum error.
        start_load();
        good_frame(8'h96);
        run_frame(0, 1'b1);

        // Oversize length.
        start_load();
        frame_q = '{8'h19, 8'h00};
        run_frame(0, 1'b1);

        // Random input stalls.
        start_load();
        good_frame(8'h97);
        run_frame(5, 1'b1);

        // Zero length.
        start_load();
        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame(0, 1'b1);

        // Abort by reset after six payload bytes; word 1 must never be written.
        start_load();
        frame_q = '{8'h03, 8'h00, 8'h13, 8'h03, 8'h10, 8'h00, 8'h93, 8'h03};
        run_frame(0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", bus.In_Ready, 0);
        check("abort_hold", bus.Cpu_Hold, 1);
        check("abort_wr_en", bus.Inst_Wr_En, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_sb_empty", 64'(exp_q.size()), 0);

        // Restart with Start toggling during the frame.
        start_load();
        good_frame(8'h97);
        start_noise = 1'b1;
        run_frame(0, 1'b1);
        start_noise = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 64'(cyc), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
